// File: rtl/dm_load_unit.sv
// MEM-stage load unit: accepts one load at a time, reads an aligned memory beat,
// then extracts and extends the result. Optional macro DMLOAD_SPLIT_EN splits misaligned loads over two beats.
module dm_load_unit #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);
  localparam int unsigned LANES = DW / 8;
  localparam int unsigned LB    = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
`ifdef DMLOAD_SPLIT_EN
    ,
    REQ2,
    WAIT2
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
`ifdef DMLOAD_SPLIT_EN
  logic [DW-1:0] beat0_q, beat0_d;
  logic          cross;
`endif

  logic          req_legal;
  int unsigned   req_nb;
  logic [AW-1:0] base;
  logic [LB-1:0] lane;
  logic [2*DW-1:0] window;
  logic [DW-1:0] shifted;

  function automatic int unsigned op_bytes(input logic [2:0] op);
    case (op)
      3'b001, 3'b010: return 1;
      3'b011, 3'b100: return 2;
      3'b000, 3'b101: return 4;
      3'b110:         return 8;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [DW-1:0] extend(input logic [2:0] op, input logic [DW-1:0] s);
    logic [DW-1:0] r;
    r = s;
    case (op)
      3'b001:  begin r = '0;          r[7:0]  = s[7:0];  end
      3'b010:  begin r = {DW{s[7]}};  r[7:0]  = s[7:0];  end
      3'b011:  begin r = '0;          r[15:0] = s[15:0]; end
      3'b100:  begin r = {DW{s[15]}}; r[15:0] = s[15:0]; end
      3'b000:  begin r = {DW{s[31]}}; r[31:0] = s[31:0]; end
      3'b101:  begin r = '0;          r[31:0] = s[31:0]; end
      default: r = s;
    endcase
    return r;
  endfunction

  always_comb begin
    req_nb    = op_bytes(req_op);
    req_legal = (req_nb != 0);
    if (DW == 32 && (req_op == 3'b101 || req_op == 3'b110)) req_legal = 1'b0;
`ifndef DMLOAD_SPLIT_EN
    if ((32'(req_addr[2:0]) & (req_nb - 1)) != 0) req_legal = 1'b0;
`endif
  end

  assign base = addr_q & ~AW'(LANES - 1);
  assign lane = addr_q[LB-1:0];

  // Second beat sits above the first, so one right shift serves both the single- and two-beat cases.
  always_comb begin
    window = '0;
    window[DW-1:0] = mem_rdata;
`ifdef DMLOAD_SPLIT_EN
    if (state_q == WAIT2) begin
      window[2*DW-1:DW] = mem_rdata;
      window[DW-1:0]    = beat0_q;
    end
`endif
    shifted = DW'(window >> {lane, 3'b000});
  end

`ifdef DMLOAD_SPLIT_EN
  assign cross = (32'(lane) + op_bytes(op_q)) > LANES;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef DMLOAD_SPLIT_EN
      beat0_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef DMLOAD_SPLIT_EN
      beat0_q <= beat0_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef DMLOAD_SPLIT_EN
    beat0_d = beat0_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d = req_addr;
        op_d   = req_op;
        if (req_legal) begin
          state_d = REQ;
        end else begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      REQ: if (mem_gnt) state_d = WAIT;
      WAIT: if (mem_rvalid) begin
`ifdef DMLOAD_SPLIT_EN
        if (cross) begin
          beat0_d = mem_rdata;
          state_d = REQ2;
        end else
`endif
        begin
          data_d  = extend(op_q, shifted);
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
`ifdef DMLOAD_SPLIT_EN
      REQ2: if (mem_gnt) state_d = WAIT2;
      WAIT2: if (mem_rvalid) begin
        data_d  = extend(op_q, shifted);
        err_d   = 1'b0;
        state_d = RESP;
      end
`endif
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    case (state_q)
      IDLE: req_ready = !reset;
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = base;
      end
`ifdef DMLOAD_SPLIT_EN
      REQ2: begin
        mem_req  = 1'b1;
        mem_addr = base + AW'(LANES);
      end
`endif
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data = data_q;
  assign rsp_err  = err_q;
endmodule
